// File: rtl/uart_pkg.sv
// Shared types and width helper for the UART transmit path.
package uart_pkg;

   localparam int DATA_LENGTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      SEND = 2'd2,
      WAIT = 2'd3
   } tx_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular word buffer; push accepted when not full or when popping in the same cycle.
// Flags are registered; head word is readable combinationally from storage.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int Data_length = DATA_LENGTH_DEF,
   parameter int Depth       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [Data_length-1:0] wr_data,
   input  logic                   rd_en,
   output logic [Data_length-1:0] rd_data,
   input  logic                   clr_ovf,
   output logic                   full,
   output logic                   empty,
   output logic [clog2(Depth):0]  count,
   output logic                   overflow
);

   localparam int PTR_W = clog2(Depth);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(Depth);

   logic [Data_length-1:0] mem_q [Depth];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
   logic             push, pop;

   always_comb begin
      pop      = rd_en && !empty_q;
      push     = wr_en && (!full_q || pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
      else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
      full_d  = (count_d == FULL_CNT);
      empty_d = (count_d == '0);
      // Clear wins over a drop in the same cycle.
      if (clr_ovf)                      ovf_d = 1'b0;
      else if (wr_en && full_q && !pop) ovf_d = 1'b1;
      else                              ovf_d = ovf_q;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
      end
   end

   assign rd_data  = mem_q[rd_ptr_q];
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues host words and launches them one at a time on baud-aligned send pulses.
// Next word waits for tx_done; a watchdog in baud ticks abandons a frame that never completes.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int Data_length = DATA_LENGTH_DEF,
   parameter int Depth       = 16,
   parameter int Timeout     = 32
) (
   input  logic                   tx_clk,
   input  logic                   rst,
   input  logic [Data_length-1:0] wr_data,
   input  logic                   wr_en,
   output logic                   full,
   output logic                   empty,
   output logic [clog2(Depth):0]  count,
   output logic                   overflow,
   input  logic                   baudratetx,
   input  logic                   tx_done,
   output logic [Data_length-1:0] parallel_datain,
   output logic                   send,
   output logic                   busy,
   output logic                   err_timeout,
   input  logic                   clr_err
);

   localparam int WD_W = clog2(Timeout + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(Timeout);

   tx_state_e              state_q, state_d;
   logic                   baud_prev_q, baud_prev_d, done_prev_q, done_prev_d;
   logic [Data_length-1:0] pd_q, pd_d;
   logic                   send_q, send_d, busy_q, busy_d, err_q, err_d;
   logic [WD_W-1:0]        wdog_q, wdog_d;
   logic                   tick, done_rise, err_set;
   logic                   fifo_rd_en, fifo_empty;
   logic [Data_length-1:0] fifo_rd_data;

   uart_sync_fifo #(
      .Data_length (Data_length),
      .Depth       (Depth)
   ) u_fifo (
      .clk      (tx_clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (fifo_rd_en),
      .rd_data  (fifo_rd_data),
      .clr_ovf  (clr_err),
      .full     (full),
      .empty    (fifo_empty),
      .count    (count),
      .overflow (overflow)
   );

   always_comb begin
      baud_prev_d = baudratetx;
      done_prev_d = tx_done;
      tick        = baudratetx && !baud_prev_q;
      done_rise   = tx_done && !done_prev_q;
      state_d     = state_q;
      pd_d        = pd_q;
      send_d      = send_q;
      wdog_d      = wdog_q;
      err_set     = 1'b0;
      fifo_rd_en  = 1'b0;
      case (state_q)
         IDLE: if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            pd_d       = fifo_rd_data;
            state_d    = ARM;
         end
         ARM: if (tick) begin
            send_d  = 1'b1;
            state_d = SEND;
         end
         SEND: if (tick) begin
            send_d  = 1'b0;
            wdog_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (done_rise) begin
               state_d = IDLE;
            end else if (tick) begin
               // An expired frame is dropped; the queue simply moves on.
               wdog_d = wdog_q + WD_W'(1);
               if (wdog_d == WD_LIMIT) begin
                  err_set = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (clr_err)      err_d = 1'b0;
      else if (err_set) err_d = 1'b1;
      else              err_d = err_q;
      busy_d = (state_d != IDLE);
   end

   // Edge history resets high so the first cycle after reset never sees an edge.
   always_ff @(posedge tx_clk) begin
      if (rst) begin
         state_q     <= IDLE;
         baud_prev_q <= 1'b1;
         done_prev_q <= 1'b1;
         pd_q        <= '0;
         send_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         wdog_q      <= '0;
      end else begin
         state_q     <= state_d;
         baud_prev_q <= baud_prev_d;
         done_prev_q <= done_prev_d;
         pd_q        <= pd_d;
         send_q      <= send_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         wdog_q      <= wdog_d;
      end
   end

   assign empty           = fifo_empty;
   assign parallel_datain = pd_q;
   assign send            = send_q;
   assign busy            = busy_q;
   assign err_timeout     = err_q;

endmodule
